// File: rtl/ram_host_bridge_pkg.sv
// Shared definitions for the CPU-to-HyperRAM host bridge: FSM states,
// host mask constants, halfword ordering and the byte-mask helper.
package ram_host_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_REQ,
    ST_WDAT,
    ST_RDAT,
    ST_FIN,
    ST_ERR
  } state_t;

  localparam logic [1:0] HOST_MASK_ALL = 2'b11;
  localparam logic       HALF_LO_FIRST = 1'b1;

  // Host mask is active-high (1 = byte masked), CPU select is active-high enable.
  function automatic logic [1:0] host_mask(input logic [3:0] sel, input logic hi);
    return hi ? (HOST_MASK_ALL ^ sel[3:2]) : (HOST_MASK_ALL ^ sel[1:0]);
  endfunction

endpackage

// File: rtl/ram_bridge_pack.sv
// 16<->32 packer: beat counter, half-select and read-word assembly.
// Shared between the CPU bridge and the management path.
module ram_bridge_pack
  import ram_host_bridge_pkg::*;
#(
  parameter int unsigned BEAT_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic              i_rx,
  input  logic [15:0]       i_rxd,
  output logic [BEAT_W-1:0] o_beat,
  output logic              o_half,
  output logic [31:0]       o_rdat,
  output logic              o_rdat_vld
);

  logic [BEAT_W-1:0] r_beat;
  logic [15:0]       r_lo;
  logic [31:0]       r_rdat;
  logic              r_rdat_vld;

  assign o_beat     = r_beat;
  assign o_half     = r_beat[0] ^ ~HALF_LO_FIRST;
  assign o_rdat     = r_rdat;
  assign o_rdat_vld = r_rdat_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat     <= '0;
      r_lo       <= '0;
      r_rdat     <= '0;
      r_rdat_vld <= 1'b0;
    end else begin
      r_rdat_vld <= 1'b0;
      if (i_clr)
        r_beat <= '0;
      else if (i_step)
        r_beat <= r_beat + BEAT_W'(1);
      if (i_rx) begin
        if (!o_half) begin
          r_lo <= i_rxd;
        end else begin
          r_rdat     <= {i_rxd, r_lo};
          r_rdat_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_host_bridge.sv
// Converts 32-bit CPU word/line transactions into the 16-bit halfword
// host stream of the HyperRAM core, with alignment check and beat timeout.
module ram_host_bridge
  import ram_host_bridge_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_burst,
  input  logic [31:0] cpu_adr,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_wdat,
  output logic        cpu_wdat_ack,
  output logic [31:0] cpu_rdat,
  output logic        cpu_rdat_vld,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        host_req,
  output logic        host_rwn,
  output logic        host_burst,
  output logic [31:0] host_addr,
  input  logic        host_ack,
  output logic [1:0]  host_txm,
  output logic [15:0] host_txd,
  input  logic        host_txd_ack,
  input  logic [15:0] host_rxd,
  input  logic        host_rxd_vld
);

  localparam int unsigned BEAT_W  = $clog2(2 * LINE_WORDS);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned ALIGN_W = $clog2(LINE_WORDS * 4);

  state_t            r_state, w_next;
  logic              r_we, r_burst;
  logic [31:0]       r_adr;
  logic [3:0]        r_sel;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_done, r_wdat_ack, r_end_d;
  logic              w_blk, w_misalign, w_last, w_tx_beat, w_rx_beat, w_tmo, w_half;
  logic [BEAT_W-1:0] w_beat;

  // Block restart while the CPU is still dropping cpu_req after done/err.
  assign w_blk      = r_done | r_end_d;
  assign w_misalign = (r_adr[1:0] != 2'b00) || (r_burst && (r_adr[ALIGN_W-1:0] != '0));
  assign w_last     = (w_beat == (r_burst ? BEAT_W'(2 * LINE_WORDS - 1) : BEAT_W'(1)));
  assign w_tx_beat  = (r_state == ST_WDAT) && host_txd_ack;
  assign w_rx_beat  = (r_state == ST_RDAT) && host_rxd_vld;
  assign w_tmo      = (r_tmo == TMO_W'(TIMEOUT - 1));

  assign cpu_done     = r_done;
  assign cpu_wdat_ack = r_wdat_ack;

  ram_bridge_pack #(.BEAT_W(BEAT_W)) u_pack (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_clr      (r_state == ST_IDLE),
    .i_step     (w_tx_beat | w_rx_beat),
    .i_rx       (w_rx_beat),
    .i_rxd      (host_rxd),
    .o_beat     (w_beat),
    .o_half     (w_half),
    .o_rdat     (cpu_rdat),
    .o_rdat_vld (cpu_rdat_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (cpu_req && !w_blk) w_next = ST_CHK;
      ST_CHK:  w_next = w_misalign ? ST_ERR : ST_REQ;
      ST_REQ:  if (host_ack) w_next = r_we ? ST_WDAT : ST_RDAT;
      ST_WDAT: begin
        if (host_txd_ack) begin
          if (w_last) w_next = ST_FIN;
        end else if (w_tmo) begin
          w_next = ST_ERR;
        end
      end
      ST_RDAT: begin
        if (host_rxd_vld) begin
          if (w_last) w_next = ST_FIN;
        end else if (w_tmo) begin
          w_next = ST_ERR;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    host_req   = 1'b0;
    host_rwn   = 1'b0;
    host_burst = 1'b0;
    host_addr  = '0;
    host_txm   = '0;
    host_txd   = '0;
    cpu_err    = 1'b0;
    unique case (r_state)
      ST_REQ: begin
        host_req   = ~host_ack;
        host_rwn   = ~r_we;
        host_burst = r_burst;
        host_addr  = {r_adr[31:1], 1'b0};
      end
      ST_WDAT: begin
        host_txd = w_half ? cpu_wdat[31:16] : cpu_wdat[15:0];
        host_txm = r_burst ? 2'b00 : host_mask(r_sel, w_half);
      end
      ST_ERR:  cpu_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_burst    <= 1'b0;
      r_adr      <= '0;
      r_sel      <= '0;
      r_tmo      <= '0;
      r_done     <= 1'b0;
      r_wdat_ack <= 1'b0;
      r_end_d    <= 1'b0;
    end else begin
      r_done     <= (r_state == ST_FIN);
      r_wdat_ack <= w_tx_beat && w_half;
      r_end_d    <= r_done | cpu_err;
      if (r_state == ST_IDLE && cpu_req && !w_blk) begin
        r_we    <= cpu_we;
        r_burst <= cpu_burst;
        r_adr   <= cpu_adr;
        r_sel   <= cpu_sel;
      end
      if (r_state == ST_WDAT || r_state == ST_RDAT)
        r_tmo <= (w_tx_beat || w_rx_beat) ? '0 : r_tmo + TMO_W'(1);
      else
        r_tmo <= '0;
    end
  end

endmodule

// File: tb/tb_ram_host_bridge.sv
// Directed self-checking bench for ram_host_bridge (LINE_WORDS=4, short timeout).
module tb_ram_host_bridge;

  localparam int unsigned TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_burst;
  logic [31:0] cpu_adr;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_wdat;
  logic        cpu_wdat_ack;
  logic [31:0] cpu_rdat;
  logic        cpu_rdat_vld, cpu_done, cpu_err;
  logic        host_req, host_rwn, host_burst;
  logic [31:0] host_addr;
  logic        host_ack;
  logic [1:0]  host_txm;
  logic [15:0] host_txd;
  logic        host_txd_ack;
  logic [15:0] host_rxd;
  logic        host_rxd_vld;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] burst_exp [4] = '{32'h0001_0000, 32'h0003_0002, 32'h0005_0004, 32'h0007_0006};

  ram_host_bridge #(.LINE_WORDS(4), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_burst    (cpu_burst),
    .cpu_adr      (cpu_adr),
    .cpu_sel      (cpu_sel),
    .cpu_wdat     (cpu_wdat),
    .cpu_wdat_ack (cpu_wdat_ack),
    .cpu_rdat     (cpu_rdat),
    .cpu_rdat_vld (cpu_rdat_vld),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .host_req     (host_req),
    .host_rwn     (host_rwn),
    .host_burst   (host_burst),
    .host_addr    (host_addr),
    .host_ack     (host_ack),
    .host_txm     (host_txm),
    .host_txd     (host_txd),
    .host_txd_ack (host_txd_ack),
    .host_rxd     (host_rxd),
    .host_rxd_vld (host_rxd_vld)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic we, input logic burst, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] wdat);
    cpu_we    = we;
    cpu_burst = burst;
    cpu_adr   = adr;
    cpu_sel   = sel;
    cpu_wdat  = wdat;
    cpu_req   = 1'b1;
  endtask

  task automatic gap;
    cpu_req = 1'b0;
    tick;
    tick;
  endtask

  task automatic single_read(input logic [31:0] adr, input logic [15:0] lo,
                             input logic [15:0] hi, input logic [31:0] exp);
    start(1'b0, 1'b0, adr, 4'hF, 32'h0);
    tick;
    chk("rd_chk_noreq", host_req, 0);
    tick;
    chk("rd_req", host_req, 1);
    chk("rd_rwn", host_rwn, 1);
    chk("rd_burst", host_burst, 0);
    chk("rd_addr", host_addr, adr);
    host_ack = 1'b1;
    #1;
    chk("rd_req_drop", host_req, 0);
    tick;
    host_ack     = 1'b0;
    host_rxd     = lo;
    host_rxd_vld = 1'b1;
    tick;
    chk("rd_vld_early", cpu_rdat_vld, 0);
    host_rxd = hi;
    tick;
    host_rxd_vld = 1'b0;
    chk("rd_vld", cpu_rdat_vld, 1);
    chk("rd_dat", cpu_rdat, exp);
    chk("rd_done_early", cpu_done, 0);
    tick;
    chk("rd_done", cpu_done, 1);
    chk("rd_vld_once", cpu_rdat_vld, 0);
    cpu_req = 1'b0;
    tick;
    chk("rd_done_once", cpu_done, 0);
    tick;
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_burst = 1'b0;
    cpu_adr = 32'h0; cpu_sel = 4'h0; cpu_wdat = 32'hFFFF_FFFF;
    host_ack = 1'b0; host_txd_ack = 1'b0; host_rxd = 16'h0; host_rxd_vld = 1'b0;
    tick;
    tick;
    chk("rst_host_req", host_req, 0);
    chk("rst_host_txd", host_txd, 0);
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_cpu_err", cpu_err, 0);
    chk("rst_cpu_rdat", cpu_rdat, 0);
    rst = 1'b1;
    tick;

    single_read(32'h0000_0100, 16'hBEEF, 16'hDEAD, 32'hDEAD_BEEF);

    // Single write, upper-low byte only enabled.
    start(1'b1, 1'b0, 32'h0000_0204, 4'b0100, 32'h1122_3344);
    tick;
    tick;
    chk("wr_rwn", host_rwn, 0);
    chk("wr_addr", host_addr, 32'h0000_0204);
    host_ack = 1'b1;
    tick;
    host_ack = 1'b0;
    chk("wr_txd0", host_txd, 16'h3344);
    chk("wr_txm0", host_txm, 2'b11);
    host_txd_ack = 1'b1;
    tick;
    chk("wr_txd1", host_txd, 16'h1122);
    chk("wr_txm1", host_txm, 2'b10);
    chk("wr_wack_early", cpu_wdat_ack, 0);
    tick;
    host_txd_ack = 1'b0;
    chk("wr_wack", cpu_wdat_ack, 1);
    chk("wr_done_early", cpu_done, 0);
    tick;
    chk("wr_done", cpu_done, 1);
    chk("wr_wack_once", cpu_wdat_ack, 0);
    gap;

    // Burst read of one line.
    start(1'b0, 1'b1, 32'h0000_0040, 4'h0, 32'h0);
    tick;
    tick;
    chk("br_burst", host_burst, 1);
    chk("br_addr", host_addr, 32'h0000_0040);
    host_ack = 1'b1;
    tick;
    host_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      host_rxd     = 16'(i);
      host_rxd_vld = 1'b1;
      tick;
      if (i % 2 == 1) begin
        chk("br_vld", cpu_rdat_vld, 1);
        chk("br_dat", cpu_rdat, burst_exp[i/2]);
      end else begin
        chk("br_vld_low", cpu_rdat_vld, 0);
      end
    end
    host_rxd_vld = 1'b0;
    chk("br_done_early", cpu_done, 0);
    tick;
    chk("br_done", cpu_done, 1);
    gap;

    // Misaligned single and burst.
    start(1'b0, 1'b0, 32'h0000_0002, 4'hF, 32'h0);
    tick;
    chk("mis1_err_c1", cpu_err, 0);
    tick;
    chk("mis1_err", cpu_err, 1);
    chk("mis1_noreq", host_req, 0);
    gap;
    chk("mis1_err_once", cpu_err, 0);
    start(1'b0, 1'b1, 32'h0000_0008, 4'hF, 32'h0);
    tick;
    chk("mis2_noreq_c1", host_req, 0);
    tick;
    chk("mis2_err", cpu_err, 1);
    chk("mis2_noreq", host_req, 0);
    gap;

    // Timeout after the first halfword of a single read.
    start(1'b0, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
    tick;
    tick;
    host_ack = 1'b1;
    tick;
    host_ack     = 1'b0;
    host_rxd     = 16'h1234;
    host_rxd_vld = 1'b1;
    tick;
    host_rxd_vld = 1'b0;
    for (int k = 1; k < int'(TMO); k++) begin
      tick;
      chk("tmo_early", cpu_err, 0);
    end
    tick;
    chk("tmo_err", cpu_err, 1);
    chk("tmo_done", cpu_done, 0);
    cpu_req = 1'b0;
    tick;
    chk("tmo_err_once", cpu_err, 0);
    host_rxd     = 16'hFFFF;
    host_rxd_vld = 1'b1;
    tick;
    host_rxd_vld = 1'b0;
    chk("late_vld", cpu_rdat_vld, 0);
    chk("late_dat", cpu_rdat, 32'h0007_0006);
    chk("late_noreq", host_req, 0);
    tick;

    // Async reset after three acks of a burst write.
    start(1'b1, 1'b1, 32'h0000_0080, 4'h0, 32'hAAAA_5555);
    tick;
    tick;
    host_ack = 1'b1;
    tick;
    host_ack = 1'b0;
    chk("bw_txm", host_txm, 2'b00);
    host_txd_ack = 1'b1;
    tick;
    tick;
    tick;
    host_txd_ack = 1'b0;
    chk("bw_txd3", host_txd, 16'hAAAA);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_host_req", host_req, 0);
    chk("ar_host_txd", host_txd, 0);
    chk("ar_host_txm", host_txm, 0);
    chk("ar_host_addr", host_addr, 0);
    chk("ar_wdat_ack", cpu_wdat_ack, 0);
    chk("ar_rdat", cpu_rdat, 0);
    chk("ar_rdat_vld", cpu_rdat_vld, 0);
    chk("ar_done", cpu_done, 0);
    chk("ar_err", cpu_err, 0);
    cpu_req = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    single_read(32'h0000_0300, 16'h5A5A, 16'hA5A5, 32'hA5A5_5A5A);

    // Beat arriving in the very cycle the timeout would expire.
    start(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'hCAFE_F00D);
    tick;
    tick;
    host_ack = 1'b1;
    tick;
    host_ack = 1'b0;
    repeat (TMO - 1) tick;
    chk("aw_err_pre", cpu_err, 0);
    chk("aw_txd0", host_txd, 16'hF00D);
    host_txd_ack = 1'b1;
    tick;
    chk("aw_err", cpu_err, 0);
    chk("aw_txd1", host_txd, 16'hCAFE);
    chk("aw_txm1", host_txm, 2'b00);
    tick;
    host_txd_ack = 1'b0;
    chk("aw_wack", cpu_wdat_ack, 1);
    tick;
    chk("aw_done", cpu_done, 1);
    gap;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
